// File: rtl/clk_freq_meter.sv
`timescale 1ns/1ps
// clk_freq_meter: counts rising edges of an asynchronous divided clock over a fixed
// CLOCK-cycle gate window. Define CLK_FREQ_METER_AUTORUN_EN for back-to-back windows.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int EXP_COUNT   = 62,
  parameter int TOL         = 1,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic             clk_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             in_range,
  output logic             overflow
);

`ifdef CLK_FREQ_METER_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int EXT_W  = (CNT_W < 32) ? 32 : CNT_W + 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  // Lower bound clamps at zero instead of wrapping when TOL exceeds EXP_COUNT.
  localparam logic [EXT_W-1:0] LO_BOUND = (EXP_COUNT > TOL) ? EXT_W'(EXP_COUNT - TOL) : '0;
  localparam logic [EXT_W-1:0] HI_BOUND = EXT_W'(EXP_COUNT + TOL);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} state_t;

  state_t             r_state;
  logic               r_s1, r_s2, r_s3;
  logic [GATE_W-1:0]  r_gate;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_ovf;

  logic               w_edge;
  logic               w_sat;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_next_ovf;
  logic [EXT_W-1:0]   w_next_ext;
  logic               w_next_in_range;
  logic               w_gate_end;
  logic               w_go;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge          = r_s2 & ~r_s3;
  assign w_sat           = &r_edge_cnt;
  assign w_next_cnt      = (w_edge && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_next_ovf      = r_ovf | (w_edge & w_sat);
  assign w_next_ext      = EXT_W'(w_next_cnt);
  assign w_next_in_range = !w_next_ovf && (w_next_ext >= LO_BOUND) && (w_next_ext <= HI_BOUND);
  assign w_gate_end      = (r_gate == GATE_LAST);
  assign w_go            = AUTORUN | start;

  // Results are latched on the last MEASURE edge so done and the data appear together.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_gate     <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      in_range   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (w_go) begin
            r_state    <= S_MEASURE;
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_MEASURE: begin
          r_gate     <= r_gate + GATE_W'(1);
          r_edge_cnt <= w_next_cnt;
          r_ovf      <= w_next_ovf;
          if (w_gate_end) begin
            r_state  <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            count    <= w_next_cnt;
            overflow <= w_next_ovf;
            in_range <= w_next_in_range;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (AUTORUN) begin
            r_state    <= S_MEASURE;
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            busy       <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
// Bench for clk_freq_meter: random divided clocks, scoreboard of gate windows,
// edge counts derived from a time-stamped log of clk_in rising edges.
module tb_clk_freq_meter;

  localparam int  G   = 1000;
  localparam int  EXP = 62;
  localparam int  TOL = 1;
  localparam int  W   = 16;
  localparam int  WN  = 4;
  localparam real TCK = 10.0;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic          clk_in = 1'b0;
  logic          busy, done, in_range, overflow;
  logic [W-1:0]  count;
  logic          busy_n, done_n, in_range_n, overflow_n;
  logic [WN-1:0] count_n;

  int n_vec = 0;
  int n_err = 0;
  int half_ns = 0;
  bit stuck_val = 1'b0;
  int last_cnt = 0;
  int last_cnt_n = 0;

  typedef struct {
    real lo;
    real hi;
    real done_t;
  } win_t;

  real  edge_q[$];
  win_t exp_q[$];

  clk_freq_meter #(.GATE_CYCLES(G), .EXP_COUNT(EXP), .TOL(TOL), .CNT_W(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .clk_in(clk_in),
    .busy(busy), .done(done), .count(count), .in_range(in_range), .overflow(overflow)
  );

  clk_freq_meter #(.GATE_CYCLES(G), .EXP_COUNT(EXP), .TOL(TOL), .CNT_W(WN)) dut_n (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .clk_in(clk_in),
    .busy(busy_n), .done(done_n), .count(count_n), .in_range(in_range_n), .overflow(overflow_n)
  );

  always #5 CLOCK = ~CLOCK;

  // clk_in edges land at integer+0.3 ns, never on a CLOCK edge.
  initial begin
    #0.3;
    forever begin
      if (half_ns == 0) begin
        clk_in = stuck_val;
        #1;
      end else begin
        #(half_ns) clk_in = ~clk_in;
      end
    end
  end

  always @(posedge clk_in) edge_q.push_back($realtime);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int edges_in(input real lo, input real hi);
    int n = 0;
    foreach (edge_q[i]) if (edge_q[i] > lo && edge_q[i] <= hi) n++;
    return n;
  endfunction

  task automatic check_result(input string tag, input int n, input int w, input logic [31:0] cnt,
                              input logic inr, input logic ovf, output int exp_cnt);
    int maxv;
    int lo_b;
    bit e_ovf;
    bit e_inr;
    maxv    = (1 << w) - 1;
    lo_b    = (EXP > TOL) ? EXP - TOL : 0;
    e_ovf   = (n > maxv);
    exp_cnt = e_ovf ? maxv : n;
    e_inr   = !e_ovf && exp_cnt >= lo_b && exp_cnt <= EXP + TOL;
    check({tag, "_count"}, cnt, exp_cnt);
    check({tag, "_overflow"}, ovf, e_ovf);
    check({tag, "_in_range"}, inr, e_inr);
  endtask

  // Monitor: every done pulse consumes one expected window.
  always @(negedge CLOCK) begin
    if (!RESET && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        win_t e;
        int   n;
        int   c16;
        int   c4;
        e = exp_q.pop_front();
        n = edges_in(e.lo, e.hi);
        check("done_cycle", $rtoi($realtime - 5.0), $rtoi(e.done_t));
        check("done_n", done_n, 1);
        check_result("w16", n, W, count, in_range, overflow, c16);
        check_result("w4", n, WN, count_n, in_range_n, overflow_n, c4);
        last_cnt   = c16;
        last_cnt_n = c4;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_in_range"}, in_range, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_busy_n"}, busy_n, 0);
    check({tag, "_done_n"}, done_n, 0);
    check({tag, "_count_n"}, count_n, 0);
    check({tag, "_in_range_n"}, in_range_n, 0);
    check({tag, "_overflow_n"}, overflow_n, 0);
  endtask

  // One single-shot measurement; cycle 1 is the first MEASURE cycle.
  task automatic run_meas(input int half, input bit stuck, input int extra_at, input bit start_in_done);
    real t1;
    half_ns   = half;
    stuck_val = stuck;
    repeat (16) @(posedge CLOCK);
    #1 start = 1'b1;
    @(posedge CLOCK);
    t1 = $realtime;
    #1 start = 1'b0;
    exp_q.push_back('{t1 - 2.0 * TCK, t1 + (G - 2) * TCK, t1 + G * TCK});
    for (int c = 1; c <= G + 8; c++) begin
      start = (c == extra_at) || (start_in_done && c == G + 1);
      if (c == 2 || c == G / 2 || c == G) check("busy_measure", busy, 1);
      if (c == G / 2) begin
        check("hold_count", count, last_cnt);
        check("hold_count_n", count_n, last_cnt_n);
      end
      if (c == G + 1 || c == G + 3) check("busy_idle", busy, 0);
      if (c == G + 2) check("done_one_cycle", done, 0);
      @(posedge CLOCK);
      #1;
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1 reset_checks("reset");
`ifdef CLK_FREQ_METER_AUTORUN_EN
    begin
      real te;
      half_ns = 80;
      RESET   = 1'b0;
      te = $realtime - 1.0 + TCK;
      for (int k = 0; k < 3; k++) begin
        real t1;
        t1 = te + k * (G + 1) * TCK;
        exp_q.push_back('{t1 - 2.0 * TCK, t1 + (G - 2) * TCK, t1 + G * TCK});
      end
      for (int c = 0; c < 3 * (G + 1) + 15; c++) begin
        start = (c == 700);
        if (c == 700) check("busy_autorun", busy, 1);
        @(posedge CLOCK);
        #1;
      end
      start = 1'b0;
      check("autorun_pending", exp_q.size(), 0);
    end
`else
    RESET = 1'b0;
    run_meas(80, 1'b0, 0, 1'b0);
    run_meas(20, 1'b0, 500, 1'b0);
    run_meas(0, 1'b0, 0, 1'b1);
    run_meas(0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_meas(int'($urandom_range(11, 120)), 1'b0, int'($urandom_range(2, G)), 1'($urandom_range(0, 1)));

    // Abort a measurement with RESET at cycle 300: no done may follow.
    half_ns = 80;
    @(posedge CLOCK);
    #1 start = 1'b1;
    @(posedge CLOCK);
    #1 start = 1'b0;
    repeat (299) @(posedge CLOCK);
    #1 RESET = 1'b1;
    #1 reset_checks("abort");
    exp_q.delete();
    last_cnt   = 0;
    last_cnt_n = 0;
    @(posedge CLOCK);
    #1 RESET = 1'b0;
    repeat (G + 20) @(posedge CLOCK);
    #1;
    check("busy_after_abort", busy, 0);
    check("count_after_abort", count, 0);
    run_meas(80, 1'b0, 0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
